spi_ram_burst: RTL and testbench
================================

// Module: spi_ram_burst
// PURPOSE
//  Parametrised single-port synchronous RAM behind the SPI slave command interface.
//  The block decodes 2-bit opcode command words into four operations:
//    - write-address load
//    - write data
//    - read-address load
//    - read data
//  New over the previous generation:
//    - address auto-increment for burst transfers
//    - tx_valid/tx_ready output handshake with rx_ready backpressure
//    - out-of-range address detection
// PARAMETERS
//  MEM_DEPTH  256  number of words; 2 <= MEM_DEPTH <= 2**ADDR_SIZE
//  ADDR_SIZE  8    address width; must be <= MEM_WIDTH
//  MEM_WIDTH  8    data word width
//  AUTO_INC   1    1: post-increment addr_wr on write-data and addr_rd on read-data; 0: addresses static
// PORTS
//  clk       in   1            rising-edge clock
//  rst_n     in   1            asynchronous active-low reset
//  din       in   MEM_WIDTH+2  command: [MEM_WIDTH+1:MEM_WIDTH]=opcode, [MEM_WIDTH-1:0]=payload
//  rx_valid  in   1            din valid this cycle
//  rx_ready  out  1            block can accept a command (combinational)
//  dout      out  MEM_WIDTH    read data
//  tx_valid  out  1            dout valid; held until accepted
//  tx_ready  in   1            consumer accepts dout
//  addr_err  out  1            1-cycle pulse: rejected address load
// BEHAVIOUR
//  Reset (async, rst_n=0): dout=0, tx_valid=0, addr_err=0, addr_wr=0, addr_rd=0, state=IDLE.
//   Memory contents are not reset.
//  Accept: command taken on a clk edge where rx_valid && rx_ready; otherwise din is ignored.
//  rx_ready = !(tx_valid && !tx_ready)
//   A pending unaccepted read stalls all commands, including writes.
//  Opcodes (payload = din[MEM_WIDTH-1:0]; address = payload[ADDR_SIZE-1:0]):
//   00: addr_wr <= address
//   01: mem[addr_wr] <= payload; if AUTO_INC, addr_wr advances
//   10: addr_rd <= address
//   11: dout <= mem[addr_rd]; tx_valid <= 1; if AUTO_INC, addr_rd advances
//  Address range check:
//   - Out of range = payload[MEM_WIDTH-1:ADDR_SIZE] != 0, or address >= MEM_DEPTH.
//   - On 00/10 with an out-of-range address: address register unchanged, addr_err=1 for the
//     next cycle only.
//  Advance/wrap: addr == MEM_DEPTH-1 -> 0, else addr+1. Modulo MEM_DEPTH, not 2**ADDR_SIZE.
//  Read latency: read command accepted at edge N -> dout/tx_valid valid after edge N
//   (visible in cycle N+1).
//  Read-after-write: a read of a location written at an earlier edge returns the new data.
//  State machine (state_q; tx_valid = (state_q == OUT_PEND)):
//   IDLE -> OUT_PEND: on an accepted opcode 11.
//   OUT_PEND, tx_ready=0: hold. dout stable, rx_ready=0.
//   OUT_PEND, tx_ready=1: output accepted this edge.
//    - Accepted opcode 11 in the same cycle: stay in OUT_PEND with new dout
//      (back-to-back reads, 1 word/cycle).
//    - Otherwise: IDLE. dout keeps its last value.
//  Simultaneous events:
//   - One command per cycle; no write/read conflict is possible.
//   - addr_err and tx_valid are independent.
//  Reset mid-operation:
//   - Pending tx_valid drops immediately (asynchronously).
//   - Burst address state is lost; the next burst must reload addresses.
// TESTING
//  1 Assert rst_n=0 mid-clock. Expect dout=0, tx_valid=0, addr_err=0, rx_ready=1
//    immediately, before the next edge.
//  2 Send 00_10, 01_A5, 10_10, 11_xx with tx_ready=1. Expect dout=A5 and tx_valid=1 for
//    exactly one cycle, one cycle after the 11 command.
//  3 Burst with AUTO_INC=1: 00_FE, 01_11, 01_22, 01_33, then 10_FE, 11, 11, 11.
//    Expect dout 11, 22, 33 on consecutive cycles (mem[00]=33, wrap).
//  4 Backpressure: tx_ready=0 after a read. Expect tx_valid and dout held and rx_ready=0;
//    a 01 write presented meanwhile is not performed. After tx_ready=1, the retried
//    command completes.
//  5 MEM_DEPTH=200: send 00_C8. Expect addr_err=1 for 1 cycle and addr_wr unchanged.
//    A burst from C7 wraps to 00.
//  6 Drop rst_n while OUT_PEND with tx_ready=0. Expect tx_valid=0 at once; after release
//    addresses=0 and memory retained.

Source files
------------

// File: rtl/spi_ram_burst.sv
// SPI-slave command RAM: 2-bit opcode words load addresses, write data and read data.
// Bursts auto-increment modulo MEM_DEPTH; reads leave through a tx_valid/tx_ready handshake.
module spi_ram_burst #(
   parameter int unsigned MEM_DEPTH = 256,
   parameter int unsigned ADDR_SIZE = 8,
   parameter int unsigned MEM_WIDTH = 8,
   parameter int unsigned AUTO_INC  = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [MEM_WIDTH+1:0] din,
   input  logic                 rx_valid,
   output logic                 rx_ready,
   output logic [MEM_WIDTH-1:0] dout,
   output logic                 tx_valid,
   input  logic                 tx_ready,
   output logic                 addr_err
);

   localparam logic [1:0] OP_WR_ADDR = 2'b00;
   localparam logic [1:0] OP_WR_DATA = 2'b01;
   localparam logic [1:0] OP_RD_ADDR = 2'b10;
   localparam logic [1:0] OP_RD_DATA = 2'b11;

   localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(MEM_DEPTH - 1);
   localparam logic [ADDR_SIZE:0]   DEPTH_EXT = (ADDR_SIZE + 1)'(MEM_DEPTH);
   localparam logic [ADDR_SIZE-1:0] ADDR_ONE  = ADDR_SIZE'(1);

   typedef enum logic {
      IDLE     = 1'b0,
      OUT_PEND = 1'b1
   } state_t;

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [ADDR_SIZE-1:0]   r_addr_wr;
   logic [ADDR_SIZE-1:0]   r_addr_rd;
   logic [MEM_WIDTH-1:0]   r_dout;
   logic                   r_addr_err;
   logic [MEM_WIDTH-1:0]   r_mem [MEM_DEPTH];

   logic [1:0]             w_opcode;
   logic [MEM_WIDTH-1:0]   w_payload;
   logic [MEM_WIDTH-1:0]   w_payload_hi;
   logic [ADDR_SIZE-1:0]   w_addr;
   logic                   w_range_bad;
   logic                   w_accept;
   logic                   w_ld_wr;
   logic                   w_wr_en;
   logic                   w_ld_rd;
   logic                   w_rd_en;
   logic                   w_err_nxt;
   logic [ADDR_SIZE-1:0]   w_wr_adv;
   logic [ADDR_SIZE-1:0]   w_rd_adv;

   assign w_opcode     = din[MEM_WIDTH+1:MEM_WIDTH];
   assign w_payload    = din[MEM_WIDTH-1:0];
   assign w_addr       = w_payload[ADDR_SIZE-1:0];
   // Bits above the address field; shifting also covers ADDR_SIZE == MEM_WIDTH.
   assign w_payload_hi = w_payload >> ADDR_SIZE;
   assign w_range_bad  = (w_payload_hi != '0) || ({1'b0, w_addr} >= DEPTH_EXT);

   // An unaccepted read result blocks every command, writes included.
   assign tx_valid = (r_state == OUT_PEND);
   assign rx_ready = !(tx_valid && !tx_ready);
   assign w_accept = rx_valid && rx_ready;

   assign dout     = r_dout;
   assign addr_err = r_addr_err;

   // Wrap is modulo MEM_DEPTH, not the power of two of the address width.
   assign w_wr_adv = (AUTO_INC == 0) ? r_addr_wr :
                     (r_addr_wr == LAST_ADDR) ? '0 : r_addr_wr + ADDR_ONE;
   assign w_rd_adv = (AUTO_INC == 0) ? r_addr_rd :
                     (r_addr_rd == LAST_ADDR) ? '0 : r_addr_rd + ADDR_ONE;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // Command decode and output-handshake next state.
   always_comb begin
      w_state_nxt = r_state;
      w_ld_wr     = 1'b0;
      w_wr_en     = 1'b0;
      w_ld_rd     = 1'b0;
      w_rd_en     = 1'b0;
      w_err_nxt   = 1'b0;
      if (w_accept) begin
         case (w_opcode)
            OP_WR_ADDR: begin
               if (w_range_bad) w_err_nxt = 1'b1;
               else             w_ld_wr   = 1'b1;
            end
            OP_WR_DATA: w_wr_en = 1'b1;
            OP_RD_ADDR: begin
               if (w_range_bad) w_err_nxt = 1'b1;
               else             w_ld_rd   = 1'b1;
            end
            OP_RD_DATA: w_rd_en = 1'b1;
         endcase
      end
      case (r_state)
         IDLE:     if (w_rd_en) w_state_nxt = OUT_PEND;
         OUT_PEND: if (tx_ready && !w_rd_en) w_state_nxt = IDLE;
         default:  w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr_wr  <= '0;
         r_addr_rd  <= '0;
         r_dout     <= '0;
         r_addr_err <= 1'b0;
      end else begin
         r_addr_err <= w_err_nxt;
         if (w_ld_wr)      r_addr_wr <= w_addr;
         else if (w_wr_en) r_addr_wr <= w_wr_adv;
         if (w_ld_rd)      r_addr_rd <= w_addr;
         else if (w_rd_en) r_addr_rd <= w_rd_adv;
         if (w_rd_en)      r_dout    <= r_mem[r_addr_rd];
      end
   end

   // Storage array; contents survive reset.
   always_ff @(posedge clk) begin
      if (w_wr_en) r_mem[r_addr_wr] <= w_payload;
   end

endmodule

// File: tb/tb_spi_ram_burst.sv
// Bench for spi_ram_burst: three configurations share one stimulus stream and are
// checked every cycle against a per-configuration array/arithmetic model.
module tb_spi_ram_burst;

   logic       clk;
   logic       rst_n;
   logic [9:0] din;
   logic       rx_valid;
   logic       tx_ready;

   logic [7:0] dout_w   [3];
   logic       txv_w    [3];
   logic       err_w    [3];
   logic       rxr_w    [3];

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   // Model state, index 0: depth 256 inc, 1: depth 200 inc, 2: depth 256 static.
   int         m_depth [3] = '{256, 200, 256};
   bit         m_inc   [3] = '{1'b1, 1'b1, 1'b0};
   logic [7:0] m_mem   [3][256];
   bit         m_kn    [3][256];
   int         m_awr   [3];
   int         m_ard   [3];
   logic [7:0] m_dout  [3];
   bit         m_dk    [3];
   bit         m_txv   [3];
   bit         m_err   [3];

   spi_ram_burst u_d256 (
      .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid), .rx_ready(rxr_w[0]),
      .dout(dout_w[0]), .tx_valid(txv_w[0]), .tx_ready(tx_ready), .addr_err(err_w[0]));

   spi_ram_burst #(.MEM_DEPTH(200)) u_d200 (
      .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid), .rx_ready(rxr_w[1]),
      .dout(dout_w[1]), .tx_valid(txv_w[1]), .tx_ready(tx_ready), .addr_err(err_w[1]));

   spi_ram_burst #(.AUTO_INC(0)) u_static (
      .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid), .rx_ready(rxr_w[2]),
      .dout(dout_w[2]), .tx_valid(txv_w[2]), .tx_ready(tx_ready), .addr_err(err_w[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         m_awr[i]  = 0;
         m_ard[i]  = 0;
         m_dout[i] = 8'h00;
         m_dk[i]   = 1'b1;
         m_txv[i]  = 1'b0;
         m_err[i]  = 1'b0;
      end
   endtask

   task automatic model_step();
      int  op;
      int  pl;
      bit  acc;
      op = int'(din[9:8]);
      pl = int'(din[7:0]);
      if (!rst_n) begin
         model_reset();
         return;
      end
      for (int i = 0; i < 3; i++) begin
         acc      = rx_valid && !(m_txv[i] && !tx_ready);
         m_err[i] = 1'b0;
         if (m_txv[i] && tx_ready) m_txv[i] = 1'b0;
         if (acc) begin
            case (op)
               0: if (pl < m_depth[i]) m_awr[i] = pl; else m_err[i] = 1'b1;
               1: begin
                  m_mem[i][m_awr[i]] = 8'(pl);
                  m_kn[i][m_awr[i]]  = 1'b1;
                  if (m_inc[i]) m_awr[i] = (m_awr[i] + 1) % m_depth[i];
               end
               2: if (pl < m_depth[i]) m_ard[i] = pl; else m_err[i] = 1'b1;
               default: begin
                  m_dout[i] = m_mem[i][m_ard[i]];
                  m_dk[i]   = m_kn[i][m_ard[i]];
                  m_txv[i]  = 1'b1;
                  if (m_inc[i]) m_ard[i] = (m_ard[i] + 1) % m_depth[i];
               end
            endcase
         end
      end
   endtask

   // Drive one cycle of inputs; model advances on the same edge as the DUTs.
   task automatic cyc(input bit v, input logic [1:0] op, input logic [7:0] pl, input bit txr);
      rx_valid = v;
      din      = {op, pl};
      tx_ready = txr;
      @(posedge clk);
      model_step();
      #2;
   endtask

   // Per-cycle comparison of every configuration against the model.
   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (m_dk[i]) chk($sformatf("dout[%0d]", i), 32'(dout_w[i]), 32'(m_dout[i]));
         chk($sformatf("tx_valid[%0d]", i), 32'(txv_w[i]), 32'(m_txv[i]));
         chk($sformatf("addr_err[%0d]", i), 32'(err_w[i]), 32'(m_err[i]));
         chk($sformatf("rx_ready[%0d]", i), 32'(rxr_w[i]), 32'(!(m_txv[i] && !tx_ready)));
      end
   end

   task automatic chk_reset_outputs(input string tag);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("%s_dout[%0d]", tag, i), 32'(dout_w[i]), 32'h0);
         chk($sformatf("%s_txv[%0d]", tag, i), 32'(txv_w[i]), 32'h0);
         chk($sformatf("%s_err[%0d]", tag, i), 32'(err_w[i]), 32'h0);
         chk($sformatf("%s_rxr[%0d]", tag, i), 32'(rxr_w[i]), 32'h1);
      end
   endtask

   initial begin
      rst_n    = 1'b0;
      rx_valid = 1'b0;
      tx_ready = 1'b1;
      din      = '0;
      model_reset();
      #1;
      chk_reset_outputs("rst0");
      @(posedge clk);
      #2;
      rst_n = 1'b1;

      // Preload every location with a known pattern.
      cyc(1, 2'b00, 8'h00, 1);
      for (int a = 0; a < 256; a++) cyc(1, 2'b01, 8'(a) ^ 8'h5A, 1);

      // Single write then read-back, one-cycle valid.
      cyc(1, 2'b00, 8'h10, 1);
      cyc(1, 2'b01, 8'hA5, 1);
      cyc(1, 2'b10, 8'h10, 1);
      cyc(1, 2'b11, 8'h00, 1);
      chk("single_dout", 32'(dout_w[0]), 32'hA5);
      chk("single_txv", 32'(txv_w[0]), 32'h1);
      cyc(0, 2'b00, 8'h00, 1);
      chk("single_txv_drop", 32'(txv_w[0]), 32'h0);

      // Burst across the 256 wrap.
      cyc(1, 2'b00, 8'hFE, 1);
      cyc(1, 2'b01, 8'h11, 1);
      cyc(1, 2'b01, 8'h22, 1);
      cyc(1, 2'b01, 8'h33, 1);
      cyc(1, 2'b10, 8'hFE, 1);
      cyc(1, 2'b11, 8'h00, 1);
      chk("burst0", 32'(dout_w[0]), 32'h11);
      cyc(1, 2'b11, 8'h00, 1);
      chk("burst1", 32'(dout_w[0]), 32'h22);
      cyc(1, 2'b11, 8'h00, 1);
      chk("burst2", 32'(dout_w[0]), 32'h33);
      chk("burst_txv", 32'(txv_w[0]), 32'h1);
      cyc(0, 2'b00, 8'h00, 1);

      // Backpressure stalls a write until the read result is taken.
      cyc(1, 2'b00, 8'h30, 1);
      cyc(1, 2'b10, 8'h30, 1);
      cyc(1, 2'b11, 8'h00, 0);
      for (int k = 0; k < 3; k++) begin
         cyc(1, 2'b01, 8'h77, 0);
         chk("bp_txv", 32'(txv_w[0]), 32'h1);
         chk("bp_dout", 32'(dout_w[0]), 32'h6A);
         chk("bp_rxr", 32'(rxr_w[0]), 32'h0);
      end
      cyc(1, 2'b01, 8'h77, 1);
      chk("bp_release_txv", 32'(txv_w[0]), 32'h0);
      cyc(1, 2'b10, 8'h30, 1);
      cyc(1, 2'b11, 8'h00, 1);
      chk("bp_retry_data", 32'(dout_w[0]), 32'h77);
      cyc(1, 2'b11, 8'h00, 1);
      chk("bp_next_untouched", 32'(dout_w[0]), 32'h6B);

      // Depth-200 range check and wrap.
      cyc(1, 2'b00, 8'hC7, 1);
      cyc(1, 2'b00, 8'hC8, 1);
      chk("range_err200", 32'(err_w[1]), 32'h1);
      chk("range_ok256", 32'(err_w[0]), 32'h0);
      cyc(1, 2'b01, 8'hAA, 1);
      chk("range_err_pulse", 32'(err_w[1]), 32'h0);
      cyc(1, 2'b01, 8'hBB, 1);
      cyc(1, 2'b10, 8'hC7, 1);
      cyc(1, 2'b11, 8'h00, 1);
      chk("wrap200_a", 32'(dout_w[1]), 32'hAA);
      cyc(1, 2'b11, 8'h00, 1);
      chk("wrap200_b", 32'(dout_w[1]), 32'hBB);
      cyc(0, 2'b00, 8'h00, 1);

      // Reset while a read result is stalled.
      cyc(1, 2'b10, 8'h05, 1);
      cyc(1, 2'b11, 8'h00, 0);
      cyc(0, 2'b00, 8'h00, 0);
      chk("pend_txv", 32'(txv_w[0]), 32'h1);
      #1;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk_reset_outputs("rst_mid");
      cyc(0, 2'b00, 8'h00, 0);
      rst_n = 1'b1;
      cyc(1, 2'b11, 8'h00, 1);
      chk("retain0", 32'(dout_w[0]), 32'h33);
      chk("retain1", 32'(dout_w[1]), 32'hBB);
      cyc(0, 2'b00, 8'h00, 1);

      // Randomized traffic biased toward the depth-200 boundary.
      for (int n = 0; n < 3000; n++) begin
         logic [7:0] pl;
         pl = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(190, 255)) : 8'($urandom);
         cyc(($urandom_range(0, 9) < 8), 2'($urandom), pl, ($urandom_range(0, 9) < 7));
      end
      cyc(0, 2'b00, 8'h00, 1);
      @(negedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
